contador_updown_param: RTL and testbench

- Parametrised, fully synchronous up/down counter.
- Successor to the 4-bit ripple up/down counter with hold, generalised in width and modulus.
- Adds parallel load, wrap or saturate mode, terminal-count output and a sticky overflow flag.
- Used as the general counting primitive in later sessions (dividers, timers, address generators).

---
 rtl/contador_updown_param.sv | 107 ++++++++++
 tb/tb_contador_updown_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_updown_param.sv
// contador_updown_param
// Parametrised synchronous up/down counter with modulus MODULO, parallel load
// (clamped to the count range), wrap or saturate at the boundaries, a
// combinational terminal-count output for cascading and a sticky OVF flag
// recording every boundary event until it is explicitly cleared.
module contador_updown_param #(
    parameter int N        = 8,
    parameter int MODULO   = 256,
    parameter bit SATURATE = 1'b0
) (
    input  logic         C,
    input  logic         nCLR,
    input  logic         nHOLD,
    input  logic         DECnINC,
    input  logic         LOAD,
    input  logic [N-1:0] D,
    input  logic         CLROVF,
    output logic [N-1:0] O,
    output logic         TC,
    output logic         OVF
);

    // Legal modulus is 2..2^N; the comparison is done in 64 bits so that
    // wide counters do not overflow the check itself.
    localparam longint MOD_L  = longint'(MODULO);
    localparam longint SPAN_L = longint'(1) << N;

    generate
        if (MOD_L < 2 || MOD_L > SPAN_L) begin : g_bad_modulo
            $error("contador_updown_param: MODULO must satisfy 2 <= MODULO <= 2^N");
        end
    endgenerate

    // Highest legal count value; also the clamp value for out-of-range loads.
    localparam logic [N-1:0] TOP = N'(MODULO - 1);

    logic [N-1:0] count_reg;
    logic [N-1:0] count_next;
    logic         ovf_reg;
    logic         ovf_next;

    logic         at_top;
    logic         at_bottom;
    logic         boundary;
    logic [N-1:0] load_value;

    assign at_top    = (count_reg == TOP);
    assign at_bottom = (count_reg == '0);

    // Out-of-range load values are clamped so the count never leaves
    // 0..MODULO-1; when MODULO = 2^N every D is already in range.
    assign load_value = (D > TOP) ? TOP : D;

    // Next count: load beats hold, hold beats count; arithmetic is modulo MODULO.
    always_comb begin
        count_next = count_reg;
        boundary   = 1'b0;
        if (LOAD) begin
            count_next = load_value;
        end else if (nHOLD) begin
            if (!DECnINC) begin
                if (at_top) begin
                    boundary   = 1'b1;
                    count_next = SATURATE ? TOP : '0;
                end else begin
                    count_next = count_reg + N'(1);
                end
            end else begin
                if (at_bottom) begin
                    boundary   = 1'b1;
                    count_next = SATURATE ? '0 : TOP;
                end else begin
                    count_next = count_reg - N'(1);
                end
            end
        end
    end

    // Sticky overflow: a boundary event sets it even if a clear is requested
    // on the same edge; loads never touch it.
    always_comb begin
        ovf_next = ovf_reg;
        if (boundary) begin
            ovf_next = 1'b1;
        end else if (CLROVF) begin
            ovf_next = 1'b0;
        end
    end

    // State registers, asynchronously cleared while nCLR is low.
    always_ff @(posedge C or negedge nCLR) begin
        if (!nCLR) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Terminal count flags the cycle before a boundary event, for cascading.
    assign TC  = nHOLD & ~LOAD & ((~DECnINC & at_top) | (DECnINC & at_bottom));

    assign O   = count_reg;
    assign OVF = ovf_reg;

endmodule

// File: tb/tb_contador_updown_param.sv
// Testbench for contador_updown_param: three instances (N=4/MOD=10/wrap,
// N=4/MOD=16/saturate, N=8/MOD=256/wrap) checked every cycle against a
// behavioural model, plus literal expectations for the directed scenarios.
module tb_contador_updown_param;

    logic       clk;
    logic       nclr   [3];
    logic       nhold  [3];
    logic       dec    [3];
    logic       load   [3];
    logic       clrovf [3];
    logic [7:0] d      [3];

    logic [3:0] o_a;
    logic [3:0] o_b;
    logic [7:0] o_c;
    logic       tc_v   [3];
    logic       ovf_v  [3];
    int         dut_o  [3];

    assign dut_o[0] = int'(o_a);
    assign dut_o[1] = int'(o_b);
    assign dut_o[2] = int'(o_c);

    contador_updown_param #(.N(4), .MODULO(10), .SATURATE(1'b0)) dut_a (
        .C(clk), .nCLR(nclr[0]), .nHOLD(nhold[0]), .DECnINC(dec[0]), .LOAD(load[0]),
        .D(d[0][3:0]), .CLROVF(clrovf[0]), .O(o_a), .TC(tc_v[0]), .OVF(ovf_v[0])
    );

    contador_updown_param #(.N(4), .MODULO(16), .SATURATE(1'b1)) dut_b (
        .C(clk), .nCLR(nclr[1]), .nHOLD(nhold[1]), .DECnINC(dec[1]), .LOAD(load[1]),
        .D(d[1][3:0]), .CLROVF(clrovf[1]), .O(o_b), .TC(tc_v[1]), .OVF(ovf_v[1])
    );

    contador_updown_param #(.N(8), .MODULO(256), .SATURATE(1'b0)) dut_c (
        .C(clk), .nCLR(nclr[2]), .nHOLD(nhold[2]), .DECnINC(dec[2]), .LOAD(load[2]),
        .D(d[2]), .CLROVF(clrovf[2]), .O(o_c), .TC(tc_v[2]), .OVF(ovf_v[2])
    );

    // Configuration of each instance as seen by the model.
    int modu  [3] = '{10, 16, 256};
    int width [3] = '{4, 4, 8};
    bit sat   [3] = '{1'b0, 1'b1, 1'b0};

    // Model state.
    int m_o   [3] = '{0, 0, 0};
    int m_ovf [3] = '{0, 0, 0};
    int cyc = 0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string nm;
        int    idx;
        int    o;
        int    ovf;
        int    tc;
    } exp_t;
    exp_t expq[$];
    event chk_ev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model, advanced on every rising clock edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!nclr[i]) begin
                m_o[i]   = 0;
                m_ovf[i] = 0;
            end else begin
                int  dv;
                bit  hit;
                hit = 1'b0;
                dv  = int'(d[i]) % (1 << width[i]);
                if (load[i]) begin
                    m_o[i] = (dv > modu[i] - 1) ? modu[i] - 1 : dv;
                end else if (nhold[i]) begin
                    if (!dec[i]) begin
                        hit = (m_o[i] == modu[i] - 1);
                        if (!(hit && sat[i])) m_o[i] = (m_o[i] + 1) % modu[i];
                    end else begin
                        hit = (m_o[i] == 0);
                        if (!(hit && sat[i])) m_o[i] = (m_o[i] + modu[i] - 1) % modu[i];
                    end
                end
                if (hit) m_ovf[i] = 1;
                else if (clrovf[i]) m_ovf[i] = 0;
            end
        end
    end

    // Single compare process: model check on falling edges, literal checks
    // whenever expectations are queued (falling edge or explicit trigger).
    always begin : cmp
        exp_t e;
        @(negedge clk or chk_ev);
        if (clk == 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                int eo;
                int eovf;
                int etc;
                eo   = nclr[i] ? m_o[i] : 0;
                eovf = nclr[i] ? m_ovf[i] : 0;
                etc  = (nhold[i] && !load[i] &&
                        ((!dec[i] && eo == modu[i] - 1) || (dec[i] && eo == 0))) ? 1 : 0;
                total++;
                if (dut_o[i] != eo) begin
                    bad++;
                    $display("FAIL model_o dut%0d cyc=%0d got=%0d want=%0d", i, cyc, dut_o[i], eo);
                end
                total++;
                if (int'(ovf_v[i]) != eovf) begin
                    bad++;
                    $display("FAIL model_ovf dut%0d cyc=%0d got=%0d want=%0d", i, cyc, ovf_v[i], eovf);
                end
                total++;
                if (int'(tc_v[i]) != etc) begin
                    bad++;
                    $display("FAIL model_tc dut%0d cyc=%0d got=%0d want=%0d", i, cyc, tc_v[i], etc);
                end
            end
        end
        while (expq.size() > 0) begin
            e = expq.pop_front();
            $display("chk %s dut%0d o=%0d ovf=%0d tc=%0d", e.nm, e.idx, dut_o[e.idx],
                     ovf_v[e.idx], tc_v[e.idx]);
            total++;
            if (dut_o[e.idx] != e.o) begin
                bad++;
                $display("FAIL %s_o dut%0d got=%0d want=%0d", e.nm, e.idx, dut_o[e.idx], e.o);
            end
            if (e.ovf >= 0) begin
                total++;
                if (int'(ovf_v[e.idx]) != e.ovf) begin
                    bad++;
                    $display("FAIL %s_ovf dut%0d got=%0d want=%0d", e.nm, e.idx, ovf_v[e.idx], e.ovf);
                end
            end
            if (e.tc >= 0) begin
                total++;
                if (int'(tc_v[e.idx]) != e.tc) begin
                    bad++;
                    $display("FAIL %s_tc dut%0d got=%0d want=%0d", e.nm, e.idx, tc_v[e.idx], e.tc);
                end
            end
        end
    end

    // One directed transaction: drive, take one edge, queue the literal
    // expectation for the following falling edge.
    task automatic st(input int i, input bit nh, input bit dc, input bit ld, input int dv,
                      input bit co, input int eo, input int eovf, input int etc,
                      input string nm);
        nhold[i]  = nh;
        dec[i]    = dc;
        load[i]   = ld;
        d[i]      = 8'(dv);
        clrovf[i] = co;
        @(posedge clk);
        #1;
        expq.push_back('{nm, i, eo, eovf, etc});
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            nclr[i] = 1'b0; nhold[i] = 1'b0; dec[i] = 1'b0;
            load[i] = 1'b0; clrovf[i] = 1'b0; d[i] = 8'd0;
        end

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) expq.push_back('{"reset", i, 0, 0, 0});
        @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) nclr[i] = 1'b1;

        // Count up through the wrap, MODULO=10.
        for (int k = 1; k <= 12; k++)
            st(0, 1, 0, 0, 0, 0, k % 10, (k >= 10) ? 1 : 0, (k % 10 == 9) ? 1 : 0, "up");

        // Count down through the wrap.
        st(0, 1, 1, 0, 0, 0, 1, 1, 0, "down");
        st(0, 1, 1, 0, 0, 0, 0, 1, 1, "down");
        st(0, 1, 1, 0, 0, 0, 9, 1, 0, "down");
        st(0, 1, 1, 0, 0, 0, 8, 1, 0, "down");

        // Plain clear, then clear colliding with a boundary event.
        st(0, 1, 1, 1, 1, 0, 1, 1, 0, "ld1");
        st(0, 1, 1, 0, 0, 1, 0, 0, 1, "clrovf");
        st(0, 1, 1, 0, 0, 1, 9, 1, 0, "setwins");

        // Hold and load priority, clamp.
        st(0, 1, 0, 1, 5, 0, 5, 1, 0, "ld5");
        for (int k = 0; k < 3; k++) st(0, 0, 0, 0, 0, 0, 5, 1, 0, "hold");
        st(0, 0, 0, 1, 7, 0, 7, 1, 0, "ldhold");
        st(0, 0, 0, 1, 13, 0, 9, 1, 0, "clamp");

        // Direction change every edge.
        st(0, 1, 0, 1, 3, 0, 3, 1, 0, "ld3");
        st(0, 1, 0, 0, 0, 0, 4, 1, 0, "dir");
        st(0, 1, 1, 0, 0, 0, 3, 1, 0, "dir");
        st(0, 1, 0, 0, 0, 0, 4, 1, 0, "dir");
        st(0, 1, 1, 0, 0, 0, 3, 1, 0, "dir");

        // Saturate mode, MODULO=16.
        st(1, 1, 0, 1, 14, 0, 14, 0, 0, "ld14");
        st(1, 1, 0, 0, 0, 0, 15, 0, 1, "sat_up");
        st(1, 1, 0, 0, 0, 0, 15, 1, 1, "sat_up");
        st(1, 1, 0, 0, 0, 0, 15, 1, 1, "sat_up");
        st(1, 1, 1, 1, 1, 0, 1, 1, 0, "ld1");
        st(1, 1, 1, 0, 0, 0, 0, 1, 1, "sat_dn");
        st(1, 1, 1, 0, 0, 0, 0, 1, 1, "sat_dn");
        st(1, 1, 1, 0, 0, 0, 0, 1, 1, "sat_dn");

        // Asynchronous reset mid-count, N=8.
        st(2, 1, 0, 1, 255, 0, 255, 0, 0, "ld255");
        st(2, 1, 0, 0, 0, 0, 0, 1, 0, "wrap256");
        st(2, 1, 0, 1, 127, 0, 127, 1, 0, "ld7f");
        load[2] = 1'b0;
        @(posedge clk);
        #1;
        expq.push_back('{"up7f", 2, 128, 1, 0});
        ->chk_ev;
        #1;
        nclr[2] = 1'b0;
        #1;
        expq.push_back('{"async", 2, 0, 0, -1});
        ->chk_ev;
        @(negedge clk);
        #1;
        @(posedge clk);
        @(negedge clk);
        #1;
        nclr[2] = 1'b1;
        st(2, 1, 0, 0, 0, 0, 1, 0, 0, "post_rst");

        // Randomised phase against the model.
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < 3; i++) begin
                nclr[i]   = ($urandom_range(0, 63) != 0);
                nhold[i]  = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 15) == 0) dec[i] = ~dec[i];
                load[i]   = ($urandom_range(0, 11) == 0);
                d[i]      = 8'($urandom);
                clrovf[i] = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
